// File: rtl/leaderboard_pkg.sv
// Shared screen geometry, BCD digit type, engine states and helpers for the leaderboard overlay.
package leaderboard_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int ROW_W    = 9;
  localparam int COL_W    = 10;

  typedef logic [3:0] bcd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SORT,
    ST_CONV,
    ST_COMMIT
  } engine_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/leaderboard_ranker_bcd_serial_conv.sv
// Sequential double-dabble: one load cycle, then SCORE_W shift cycles; saturates to all nines.
module bcd_serial_conv
  import leaderboard_pkg::*;
#(
  parameter int SCORE_W  = 20,
  parameter int N_DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [SCORE_W-1:0]    value,
  output logic                  done,
  output logic [N_DIGITS*4-1:0] digits
);

  localparam int BCD_W = N_DIGITS * 4;
  localparam int CNT_W = clog2(SCORE_W + 1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0] MAX_VAL = pow10(N_DIGITS) - 64'd1;

  logic [SCORE_W-1:0] shreg;
  logic [CNT_W-1:0]   sh_cnt;
  logic               running;
  logic               sat;
  logic [BCD_W-1:0]   adj;

  always_comb begin
    adj = digits;
    for (int d = 0; d < N_DIGITS; d++) begin
      if (digits[4*d +: 4] >= 4'd5) adj[4*d +: 4] = digits[4*d +: 4] + 4'd3;
    end
  end

  // A saturated value keeps its nines; the shift cycles still elapse so timing is fixed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg   <= '0;
      sh_cnt  <= '0;
      running <= 1'b0;
      sat     <= 1'b0;
      done    <= 1'b0;
      digits  <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        shreg   <= value;
        sh_cnt  <= '0;
        running <= 1'b1;
        if (64'(value) > MAX_VAL) begin
          sat    <= 1'b1;
          digits <= {N_DIGITS{4'd9}};
        end else begin
          sat    <= 1'b0;
          digits <= '0;
        end
      end else if (running) begin
        if (!sat) begin
          digits <= {adj[BCD_W-2:0], shreg[SCORE_W-1]};
          shreg  <= shreg << 1;
        end
        if (sh_cnt == CNT_W'(SCORE_W - 1)) begin
          running <= 1'b0;
          done    <= 1'b1;
        end else begin
          sh_cnt <= sh_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/leaderboard_ranker.sv
// Per-frame score ranking and BCD conversion with atomic commit, plus registered slot/crest/digit pixel decode.
module leaderboard_ranker
  import leaderboard_pkg::*;
#(
  parameter int N_HOUSES      = 4,
  parameter int SCORE_W       = 20,
  parameter int N_DIGITS      = 6,
  parameter int BLANK_LZ      = 1,
  parameter int ROW0          = 40,
  parameter int SLOT_H        = 100,
  parameter int CREST_COL0    = 120,
  parameter int CREST_W       = 100,
  parameter int DIGIT_COL0    = 280,
  parameter int DIGIT_W       = 30,
  parameter int DIGIT_H       = 30,
  parameter int DIGIT_ROW_OFF = 35
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                enable,
  input  logic                                frame_start,
  input  logic [N_HOUSES*SCORE_W-1:0]         house_scores,
  input  logic [ROW_W-1:0]                    row,
  input  logic [COL_W-1:0]                    col,
  output logic                                busy,
  output logic [N_HOUSES-1:0]                 house_onehot,
  output logic                                crest_active,
  output logic [clog2(CREST_W*SLOT_H)-1:0]    crest_addr,
  output logic                                digit_active,
  output logic [3:0]                          digit_value,
  output logic [clog2(DIGIT_W*DIGIT_H)-1:0]   digit_addr
);

  localparam int IDX_W = clog2(N_HOUSES);
  localparam int CA_W  = clog2(CREST_W * SLOT_H);
  localparam int DA_W  = clog2(DIGIT_W * DIGIT_H);
  localparam int BCD_W = N_DIGITS * 4;
  localparam int CNT_W = clog2(SCORE_W + 1);

  if (N_HOUSES < 2 || N_HOUSES > 8 ||
      ROW0 + N_HOUSES * SLOT_H > SCREEN_H ||
      DIGIT_COL0 + N_DIGITS * DIGIT_W > SCREEN_W) begin : g_bad_geometry
    $error("leaderboard_ranker: slots or digits do not fit on the screen");
  end

  engine_state_t      state;
  logic [SCORE_W-1:0] sc        [N_HOUSES];
  logic [IDX_W-1:0]   rk        [N_HOUSES];
  logic [BCD_W-1:0]   pend      [N_HOUSES];
  logic [IDX_W-1:0]   disp_rank [N_HOUSES];
  logic [BCD_W-1:0]   disp_bcd  [N_HOUSES];
  logic [IDX_W-1:0]   sort_j, sort_pass, conv_slot, sort_j1;
  logic [CNT_W-1:0]   conv_cnt;
  logic               conv_start, conv_done;
  logic [BCD_W-1:0]   conv_digits;

  assign sort_j1    = sort_j + IDX_W'(1);
  assign conv_start = (state == ST_CONV) && (conv_cnt == '0);

  bcd_serial_conv #(
    .SCORE_W  (SCORE_W),
    .N_DIGITS (N_DIGITS)
  ) u_conv (
    .clk    (clk),
    .reset  (reset),
    .start  (conv_start),
    .value  (sc[conv_slot]),
    .done   (conv_done),
    .digits (conv_digits)
  );

  // The previous slot's digits are captured on the next slot's load cycle; the last slot's
  // result is still in the converter during COMMIT and is copied straight from there.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      sort_j    <= '0;
      sort_pass <= '0;
      conv_slot <= '0;
      conv_cnt  <= '0;
      for (int i = 0; i < N_HOUSES; i++) begin
        sc[i]        <= '0;
        rk[i]        <= '0;
        pend[i]      <= '0;
        disp_rank[i] <= IDX_W'(i);
        disp_bcd[i]  <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (frame_start) begin
            state <= ST_LOAD;
            busy  <= 1'b1;
          end
        end
        ST_LOAD: begin
          for (int i = 0; i < N_HOUSES; i++) begin
            sc[i] <= house_scores[i*SCORE_W +: SCORE_W];
            rk[i] <= IDX_W'(i);
          end
          sort_j    <= '0;
          sort_pass <= '0;
          state     <= ST_SORT;
        end
        ST_SORT: begin
          if (sc[sort_j1] > sc[sort_j]) begin
            sc[sort_j]  <= sc[sort_j1];
            sc[sort_j1] <= sc[sort_j];
            rk[sort_j]  <= rk[sort_j1];
            rk[sort_j1] <= rk[sort_j];
          end
          if (sort_j == IDX_W'(N_HOUSES - 2)) begin
            sort_j <= '0;
            if (sort_pass == IDX_W'(N_HOUSES - 2)) begin
              conv_slot <= '0;
              conv_cnt  <= '0;
              state     <= ST_CONV;
            end else begin
              sort_pass <= sort_pass + IDX_W'(1);
            end
          end else begin
            sort_j <= sort_j1;
          end
        end
        ST_CONV: begin
          if (conv_done && conv_cnt == '0 && conv_slot != '0)
            pend[conv_slot - IDX_W'(1)] <= conv_digits;
          if (conv_cnt == CNT_W'(SCORE_W)) begin
            conv_cnt <= '0;
            if (conv_slot == IDX_W'(N_HOUSES - 1)) state <= ST_COMMIT;
            else conv_slot <= conv_slot + IDX_W'(1);
          end else begin
            conv_cnt <= conv_cnt + CNT_W'(1);
          end
        end
        ST_COMMIT: begin
          for (int i = 0; i < N_HOUSES; i++) begin
            disp_rank[i] <= rk[i];
            disp_bcd[i]  <= (i == N_HOUSES - 1) ? conv_digits : pend[i];
          end
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  int               row_i, col_i, slot_top, dig_top, dig_left, dig_k, crest_a, dig_a;
  logic             in_slot, crest_hit, dig_row_hit, dig_hit, lead_zero, dig_on;
  logic [IDX_W-1:0] slot_idx;
  logic [BCD_W-1:0] sel_bcd;
  bcd_t             dig_val;

  assign row_i = 32'(row);
  assign col_i = 32'(col);

  // Region decode is purely positional so every pixel address is independent of scan history.
  always_comb begin
    in_slot  = 1'b0;
    slot_idx = '0;
    slot_top = 0;
    for (int s = 0; s < N_HOUSES; s++) begin
      if (row_i >= ROW0 + s * SLOT_H && row_i < ROW0 + (s + 1) * SLOT_H) begin
        in_slot  = 1'b1;
        slot_idx = IDX_W'(s);
        slot_top = ROW0 + s * SLOT_H;
      end
    end
    crest_hit   = in_slot && col_i >= CREST_COL0 && col_i < CREST_COL0 + CREST_W;
    crest_a     = (row_i - slot_top) * CREST_W + (col_i - CREST_COL0);
    dig_top     = slot_top + DIGIT_ROW_OFF;
    dig_row_hit = in_slot && row_i >= dig_top && row_i < dig_top + DIGIT_H;
    dig_hit     = 1'b0;
    dig_k       = 0;
    dig_left    = DIGIT_COL0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (col_i >= DIGIT_COL0 + k * DIGIT_W && col_i < DIGIT_COL0 + (k + 1) * DIGIT_W) begin
        dig_hit  = dig_row_hit;
        dig_k    = k;
        dig_left = DIGIT_COL0 + k * DIGIT_W;
      end
    end
    dig_a     = (row_i - dig_top) * DIGIT_W + (col_i - dig_left);
    sel_bcd   = disp_bcd[slot_idx];
    dig_val   = sel_bcd[4*(N_DIGITS-1-dig_k) +: 4];
    lead_zero = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (i <= dig_k && sel_bcd[4*(N_DIGITS-1-i) +: 4] != 4'd0) lead_zero = 1'b0;
    end
    dig_on = dig_hit && !((BLANK_LZ != 0) && lead_zero && dig_k < N_DIGITS - 1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      house_onehot <= '0;
      crest_active <= 1'b0;
      crest_addr   <= '0;
      digit_active <= 1'b0;
      digit_value  <= '0;
      digit_addr   <= '0;
    end else if (enable && in_slot) begin
      house_onehot <= N_HOUSES'(1) << disp_rank[slot_idx];
      crest_active <= crest_hit;
      crest_addr   <= crest_hit ? CA_W'(crest_a) : '0;
      digit_active <= dig_on;
      digit_value  <= dig_on ? dig_val : 4'd0;
      digit_addr   <= dig_on ? DA_W'(dig_a) : '0;
    end else begin
      house_onehot <= '0;
      crest_active <= 1'b0;
      crest_addr   <= '0;
      digit_active <= 1'b0;
      digit_value  <= '0;
      digit_addr   <= '0;
    end
  end

endmodule

// File: doc/leaderboard_ranker.md
Name: leaderboard_ranker

Overview:
Parametrised successor to the house leaderboard overlay for the VGA pixel pipeline.
- Snapshots N house scores once per frame and sorts them into descending rank.
- Converts each score to BCD sequentially, then commits the results atomically to display registers.
- From (row, col), generates per-slot crest and score-digit ROM addresses, a house select and a digit value for the colour mux.

Parameters:
- N_HOUSES, 4, number of houses/slots (2..8)
- SCORE_W, 20, score width in bits
- N_DIGITS, 6, decimal digits displayed
- BLANK_LZ, 1, 1 = blank leading zeros (ones digit always shown)
- ROW0, 40, top row of slot 0
- SLOT_H, 100, slot height in rows; crest height is also SLOT_H
- CREST_COL0, 120, crest left column
- CREST_W, 100, crest width
- DIGIT_COL0, 280, left column of the most-significant digit
- DIGIT_W, 30, digit width
- DIGIT_H, 30, digit height
- DIGIT_ROW_OFF, 35, digit top row offset within slot

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  leaderboard screen active
- frame_start  in  1  one-cycle pulse at frame start
- house_scores  in  N_HOUSES*SCORE_W  packed scores; house h at bits [h*SCORE_W +: SCORE_W]
- row  in  9  current pixel row
- col  in  10  current pixel column
- busy  out  1  rank/convert engine running
- house_onehot  out  N_HOUSES  house shown in the current slot, one-hot; 0 outside slots
- crest_active  out  1  pixel is inside a crest
- crest_addr  out  clog2(CREST_W*SLOT_H)  crest ROM address
- digit_active  out  1  pixel is inside a displayed digit
- digit_value  out  4  BCD value of that digit
- digit_addr  out  clog2(DIGIT_W*DIGIT_H)  digit-glyph ROM address

Behaviour:
Reset
- All outputs are 0.
- Committed display state is the identity rank (slot i = house i) with all BCD digits 0.
- Engine returns to IDLE. Reset mid-operation aborts the engine and discards partial results.

Engine FSM: IDLE -> LOAD -> SORT -> CONV -> COMMIT -> IDLE.
- IDLE: frame_start moves to LOAD. frame_start in any other state is ignored; no pending flag.
- LOAD (1 cycle): snapshot house_scores; rank list = 0..N-1.
- SORT ((N-1)^2 cycles): bubble sort, one compare per cycle, j sweeping 0..N-2 for N-1 passes.
  - Swap entries j and j+1 only if score[j+1] > score[j], strictly.
  - Ties therefore keep the lower house index at the higher rank.
- CONV (N*(SCORE_W+1) cycles): per slot, 1 load cycle, then SCORE_W double-dabble shift cycles.
  - At the load cycle, a score > 10^N_DIGITS-1 is saturated: all digits are forced to 9.
- COMMIT (1 cycle): rank list and all BCD digits are copied to the display registers in one cycle. Display never shows a partial update.
- busy is high from the cycle after frame_start through COMMIT: 2+(N-1)^2+N*(SCORE_W+1) cycles (95 at defaults).

Display (all outputs registered; 1-cycle latency from row/col)
- Slot s spans rows ROW0+s*SLOT_H .. ROW0+(s+1)*SLOT_H-1, for s < N_HOUSES.
- With enable=0 or outside every slot, all display outputs are 0.
- house_onehot = one-hot of the committed rank[s] for the whole slot row span.
- Crest region: col in [CREST_COL0, CREST_COL0+CREST_W).
  - crest_active=1; crest_addr = (row-slot_top)*CREST_W + (col-CREST_COL0).
  - Computed directly from row/col, not from a running counter.
- Digit region: rows [slot_top+DIGIT_ROW_OFF, +DIGIT_H).
  - Digit k (k=0 is most significant) spans cols [DIGIT_COL0+k*DIGIT_W, +DIGIT_W).
  - digit_addr = (row-digit_top)*DIGIT_W + (col-digit_left).
  - digit_value = committed BCD digit k of slot s.
  - digit_active=1, except when BLANK_LZ=1 and every digit 0..k is 0 with k < N_DIGITS-1; then digit_active=0 and digit_value=0.
- Engine activity never disturbs the display outputs.
- Elaboration check: ROW0+N_HOUSES*SLOT_H <= 480 and DIGIT_COL0+N_DIGITS*DIGIT_W <= 640.

Decomposition:
- Shared package leaderboard_pkg:
  - screen constants (640x480, ROW_W=9, COL_W=10)
  - BCD digit type (4-bit)
  - engine FSM state enum
  - clog2 helper function
- One natural sub-module: bcd_serial_conv, a SCORE_W-bit to N_DIGITS-digit sequential double-dabble with start/done and saturation. The ranker instantiates it once and reuses it per slot.

Test Plan:
1. Scores {G=120, H=4500, R=99, S=4500}, frame_start -> busy high exactly 95 cycles; after commit, slot order H(1), S(3), G(0), R(2) (tie keeps H first); slot0 digits 004500.
2. BLANK_LZ=1, slot0 score 4500 -> digit_active=0 at digits 0,1; digit 2 shows 4; score 0 -> only digit 5 active, value 0.
3. Score 2^20-1 (1048575) with N_DIGITS=6 -> all digits 9.
4. Pixel (row 41, col 125) -> next cycle crest_active=1, crest_addr=105. Pixel (row 76, col 312) -> digit_active=1, digit_addr=32, digit index 1. Pixel (row 20, col 125) -> all display outputs 0.
5. frame_start again at cycle 30 of busy, with changed scores -> ignored; commit reflects the first snapshot; display unchanged until COMMIT.
6. Assert reset during SORT -> outputs 0 immediately; busy=0; after release, identity rank and all-zero digits; next frame_start completes normally.
